// File: rtl/scaler_cfg_sched.sv
// scaler_cfg_sched
//   Accepts scaler configuration requests and applies them to the live
//   setting at frame boundaries. Width and height move one index per frame
//   toward the target, so the scaler never jumps more than one size step
//   between frames. Reverse and pan are loaded whole on each update.
//
// Ports
//   pixclk_in       clock (rising edge)
//   rst_i           asynchronous active-high reset
//   vs_in           input vsync; rising edge = frame boundary
//   cfg_valid_i     request offered
//   cfg_ready_o     request can be accepted (low only during reset)
//   cfg_width_i     requested width index  (0..62)
//   cfg_height_i    requested height index (0..71)
//   cfg_reverse_i   requested colour inversion
//   cfg_pan_i       requested pan index    (0..36)
//   width_idx_o     applied width index
//   height_idx_o    applied height index
//   reverse_o       applied colour inversion
//   pan_o           applied pan index
//   dest_width_o    scaler destination width  (registered from width_idx_o)
//   dest_height_o   scaler destination height (registered from height_idx_o)
//   scaler_rst_o    one-cycle pulse after every frame boundary
//   busy_o          applied setting differs from target (PEND or STEP)
//   done_o          one-cycle pulse when stepping reaches the target
//   cfg_err_o       one-cycle pulse after a rejected request
module scaler_cfg_sched (
  input  logic        pixclk_in,
  input  logic        rst_i,
  input  logic        vs_in,
  input  logic        cfg_valid_i,
  output logic        cfg_ready_o,
  input  logic [5:0]  cfg_width_i,
  input  logic [6:0]  cfg_height_i,
  input  logic        cfg_reverse_i,
  input  logic [5:0]  cfg_pan_i,
  output logic [5:0]  width_idx_o,
  output logic [6:0]  height_idx_o,
  output logic        reverse_o,
  output logic [5:0]  pan_o,
  output logic [11:0] dest_width_o,
  output logic [11:0] dest_height_o,
  output logic        scaler_rst_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        cfg_err_o
);

  typedef enum logic [1:0] {IDLE, PEND, STEP} state_t;

  state_t      state, state_nxt;
  logic        vs_d;
  logic        vs_edge;
  logic [5:0]  tw;
  logic [6:0]  th;
  logic        trev;
  logic [5:0]  tpan;
  logic        accept, req_ok, load, update, done_nxt;
  logic        req_eq, tgt_eq;
  logic [5:0]  nw;
  logic [6:0]  nh;
  logic        nrev;
  logic [5:0]  npan;

  // Width falls from 640 to 20 over indices 0..31, then rises again.
  function automatic logic [11:0] dest_w(input logic [5:0] idx);
    logic [11:0] prod;
    prod = 12'd20 * {6'd0, idx};
    if (idx <= 6'd31) dest_w = 12'd640 - prod;
    else              dest_w = prod - 12'd600;
  endfunction

  // Height falls from 720 to 20 over indices 0..35, then rises again.
  function automatic logic [11:0] dest_h(input logic [6:0] idx);
    logic [11:0] prod;
    prod = 12'd20 * {5'd0, idx};
    if (idx <= 7'd35) dest_h = 12'd720 - prod;
    else              dest_h = prod - 12'd700;
  endfunction

  assign cfg_ready_o = ~rst_i;
  assign vs_edge     = vs_in & ~vs_d;
  assign accept      = cfg_valid_i & cfg_ready_o;
  assign req_ok      = (cfg_width_i <= 6'd62) && (cfg_height_i <= 7'd71) &&
                       (cfg_pan_i <= 6'd36);
  assign load        = accept & req_ok;
  assign update      = vs_edge & (state != IDLE);
  assign busy_o      = (state != IDLE);

  // Applied setting as it will be after this cycle. An update always uses
  // the target held before this cycle, so a request landing on the same
  // frame boundary only takes effect from the next one.
  always_comb begin
    nw   = width_idx_o;
    nh   = height_idx_o;
    nrev = reverse_o;
    npan = pan_o;
    if (update) begin
      if (width_idx_o < tw)       nw = width_idx_o + 6'd1;
      else if (width_idx_o > tw)  nw = width_idx_o - 6'd1;
      if (height_idx_o < th)      nh = height_idx_o + 7'd1;
      else if (height_idx_o > th) nh = height_idx_o - 7'd1;
      nrev = trev;
      npan = tpan;
    end
  end

  assign req_eq = ({cfg_width_i, cfg_height_i, cfg_reverse_i, cfg_pan_i} ==
                   {nw, nh, nrev, npan});
  assign tgt_eq = ({tw, th, trev, tpan} == {nw, nh, nrev, npan});

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (load && !req_eq) state_nxt = PEND;
      end
      PEND: begin
        if (load) begin
          if (req_eq)       state_nxt = IDLE;
          else if (vs_edge) state_nxt = STEP;
        end else if (vs_edge) begin
          // A single-step change completes on its first frame.
          if (tgt_eq) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = STEP;
          end
        end
      end
      STEP: begin
        if (load) begin
          if (req_eq) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end else if (vs_edge && tgt_eq) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pixclk_in or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      vs_d          <= 1'b0;
      tw            <= '0;
      th            <= '0;
      trev          <= 1'b0;
      tpan          <= '0;
      width_idx_o   <= '0;
      height_idx_o  <= '0;
      reverse_o     <= 1'b0;
      pan_o         <= '0;
      dest_width_o  <= 12'd640;
      dest_height_o <= 12'd720;
      scaler_rst_o  <= 1'b0;
      done_o        <= 1'b0;
      cfg_err_o     <= 1'b0;
    end else begin
      state         <= state_nxt;
      vs_d          <= vs_in;
      width_idx_o   <= nw;
      height_idx_o  <= nh;
      reverse_o     <= nrev;
      pan_o         <= npan;
      dest_width_o  <= dest_w(width_idx_o);
      dest_height_o <= dest_h(height_idx_o);
      scaler_rst_o  <= vs_edge;
      done_o        <= done_nxt;
      cfg_err_o     <= accept & ~req_ok;
      if (load) begin
        tw   <= cfg_width_i;
        th   <= cfg_height_i;
        trev <= cfg_reverse_i;
        tpan <= cfg_pan_i;
      end
    end
  end

endmodule

// File: tb/tb_scaler_cfg_sched.sv
module tb_scaler_cfg_sched;

  logic        clk;
  logic        rst;
  logic        vs;
  logic        valid;
  logic        ready;
  logic [5:0]  cw;
  logic [6:0]  ch;
  logic        crev;
  logic [5:0]  cp;
  logic [5:0]  w_o;
  logic [6:0]  h_o;
  logic        rev_o;
  logic [5:0]  pan_o;
  logic [11:0] dw_o;
  logic [11:0] dh_o;
  logic        srst_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int srst_cnt = 0;

  scaler_cfg_sched dut (
    .pixclk_in     (clk),
    .rst_i         (rst),
    .vs_in         (vs),
    .cfg_valid_i   (valid),
    .cfg_ready_o   (ready),
    .cfg_width_i   (cw),
    .cfg_height_i  (ch),
    .cfg_reverse_i (crev),
    .cfg_pan_i     (cp),
    .width_idx_o   (w_o),
    .height_idx_o  (h_o),
    .reverse_o     (rev_o),
    .pan_o         (pan_o),
    .dest_width_o  (dw_o),
    .dest_height_o (dh_o),
    .scaler_rst_o  (srst_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .cfg_err_o     (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] w;
    logic [6:0] h;
    logic       rev;
    logic [5:0] pan;
    int         edges;
    int         ew;
    int         eh;
    int         erev;
    int         epan;
    int         edw;
    int         edh;
    int         ebusy;
    int         eerr;
    int         edone;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (done_o === 1'b1) done_cnt++;
    if (srst_o === 1'b1) srst_cnt++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic send_req(input logic [5:0] w, input logic [6:0] h,
                          input logic r, input logic [5:0] p);
    cw = w; ch = h; crev = r; cp = p;
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  // One frame boundary, followed by enough idle cycles for vs_d to clear
  // and for the registered dest values to follow the applied indices.
  task automatic vs_edge();
    vs = 1'b1;
    tick();
    vs = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int err_seen;
    rst = 1'b0; vs = 1'b0; valid = 1'b0;
    cw = '0; ch = '0; crev = 1'b0; cp = '0;

    // Vectors run back to back, each starting from the previous state.
    vecs[0] = '{6'd2,  7'd0,  1'b1, 6'd5,  2, 2,  0, 1, 5,  600, 720, 0, 0, 1};
    vecs[1] = '{6'd2,  7'd3,  1'b0, 6'd7,  1, 2,  1, 0, 7,  600, 700, 1, 0, 0};
    vecs[2] = '{6'd2,  7'd3,  1'b0, 6'd7,  2, 2,  3, 0, 7,  600, 660, 0, 0, 1};
    vecs[3] = '{6'd40, 7'd3,  1'b0, 6'd7,  0, 2,  3, 0, 7,  600, 660, 1, 0, 0};
    vecs[4] = '{6'd2,  7'd3,  1'b0, 6'd7,  0, 2,  3, 0, 7,  600, 660, 0, 0, 0};
    vecs[5] = '{6'd63, 7'd3,  1'b0, 6'd7,  0, 2,  3, 0, 7,  600, 660, 0, 1, 0};
    vecs[6] = '{6'd0,  7'd72, 1'b0, 6'd0,  0, 2,  3, 0, 7,  600, 660, 0, 1, 0};
    vecs[7] = '{6'd0,  7'd0,  1'b0, 6'd37, 0, 2,  3, 0, 7,  600, 660, 0, 1, 0};
    vecs[8] = '{6'd62, 7'd71, 1'b1, 6'd36, 1, 3,  4, 1, 36, 580, 640, 1, 0, 0};
    vecs[9] = '{6'd2,  7'd3,  1'b1, 6'd36, 1, 2,  3, 1, 36, 600, 660, 0, 0, 1};

    #1 rst = 1'b1;
    #2;
    chk("rst_width_async", int'(w_o), 0);
    chk("rst_dw_async", int'(dw_o), 640);
    chk("rst_ready_async", int'(ready), 0);
    repeat (2) tick();
    chk("rst_height", int'(h_o), 0);
    chk("rst_rev", int'(rev_o), 0);
    chk("rst_pan", int'(pan_o), 0);
    chk("rst_dh", int'(dh_o), 720);
    chk("rst_srst", int'(srst_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_err", int'(err_o), 0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", int'(ready), 1);

    for (int i = 0; i < 10; i++) begin
      done_cnt = 0;
      srst_cnt = 0;
      send_req(vecs[i].w, vecs[i].h, vecs[i].rev, vecs[i].pan);
      err_seen = int'(err_o);
      for (int e = 0; e < vecs[i].edges; e++) vs_edge();
      tick();
      chk($sformatf("v%0d_err", i),   err_seen, vecs[i].eerr);
      chk($sformatf("v%0d_w", i),     int'(w_o), vecs[i].ew);
      chk($sformatf("v%0d_h", i),     int'(h_o), vecs[i].eh);
      chk($sformatf("v%0d_rev", i),   int'(rev_o), vecs[i].erev);
      chk($sformatf("v%0d_pan", i),   int'(pan_o), vecs[i].epan);
      chk($sformatf("v%0d_dw", i),    int'(dw_o), vecs[i].edw);
      chk($sformatf("v%0d_dh", i),    int'(dh_o), vecs[i].edh);
      chk($sformatf("v%0d_busy", i),  int'(busy_o), vecs[i].ebusy);
      chk($sformatf("v%0d_done", i),  done_cnt, vecs[i].edone);
      chk($sformatf("v%0d_srst", i),  srst_cnt, vecs[i].edges);
    end

    // Long walk across the dest-size fold points (w 31/32, h 35/36).
    do_reset();
    send_req(6'd32, 7'd36, 1'b0, 6'd0);
    done_cnt = 0;
    for (int k = 1; k <= 36; k++) begin
      vs_edge();
      if (k == 31) begin
        chk("walk31_w", int'(w_o), 31);
        chk("walk31_dw", int'(dw_o), 20);
        chk("walk31_dh", int'(dh_o), 100);
      end
      if (k == 32) begin
        chk("walk32_w", int'(w_o), 32);
        chk("walk32_dw", int'(dw_o), 40);
      end
      if (k == 35) begin
        chk("walk35_h", int'(h_o), 35);
        chk("walk35_dh", int'(dh_o), 20);
        chk("walk35_busy", int'(busy_o), 1);
        chk("walk35_done", done_cnt, 0);
      end
    end
    chk("walk36_h", int'(h_o), 36);
    chk("walk36_dh", int'(dh_o), 20);
    chk("walk36_busy", int'(busy_o), 0);
    chk("walk36_done", done_cnt, 1);
    // Boundary in IDLE: reset pulse only.
    srst_cnt = 0; done_cnt = 0;
    vs_edge();
    chk("idle_edge_srst", srst_cnt, 1);
    chk("idle_edge_w", int'(w_o), 32);
    chk("idle_edge_h", int'(h_o), 36);
    chk("idle_edge_done", done_cnt, 0);

    // Retarget while stepping: w heading for 10, redirected to 2 at w=4.
    do_reset();
    send_req(6'd10, 7'd0, 1'b0, 6'd0);
    repeat (4) vs_edge();
    chk("retgt_w4", int'(w_o), 4);
    send_req(6'd2, 7'd0, 1'b0, 6'd0);
    done_cnt = 0;
    vs_edge();
    chk("retgt_w3", int'(w_o), 3);
    chk("retgt_done0", done_cnt, 0);
    vs_edge();
    chk("retgt_w2", int'(w_o), 2);
    chk("retgt_done1", done_cnt, 1);
    chk("retgt_busy", int'(busy_o), 0);

    // Request on the same cycle as a boundary: the update uses the old target.
    do_reset();
    send_req(6'd5, 7'd0, 1'b0, 6'd0);
    repeat (2) vs_edge();
    cw = 6'd0; ch = 7'd0; crev = 1'b0; cp = 6'd0;
    valid = 1'b1;
    vs = 1'b1;
    tick();
    valid = 1'b0;
    vs = 1'b0;
    chk("same_cyc_w3", int'(w_o), 3);
    chk("same_cyc_busy", int'(busy_o), 1);
    tick(); tick();
    vs_edge();
    chk("same_cyc_next_w2", int'(w_o), 2);

    // Reset in the middle of stepping, with vs held high across release.
    do_reset();
    send_req(6'd10, 7'd0, 1'b0, 6'd0);
    repeat (5) vs_edge();
    chk("mid_w5", int'(w_o), 5);
    chk("mid_dw", int'(dw_o), 540);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_w", int'(w_o), 0);
    chk("async_dw", int'(dw_o), 640);
    chk("async_busy", int'(busy_o), 0);
    chk("async_ready", int'(ready), 0);
    vs = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    srst_cnt = 0;
    tick();
    chk("rel_edge_srst", srst_cnt, 1);
    chk("rel_edge_w", int'(w_o), 0);
    vs = 1'b0;
    tick(); tick();
    done_cnt = 0;
    repeat (2) vs_edge();
    tick();
    chk("post_rst_w", int'(w_o), 0);
    chk("post_rst_dw", int'(dw_o), 640);
    chk("post_rst_busy", int'(busy_o), 0);
    chk("post_rst_done", done_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
